bird_physics: RTL and testbench

//   Vertical-motion engine for the player sprite. It integrates gravity and flap impulses once per

---
 rtl/bird_pkg.sv | 30 +++
 rtl/edge_rise.sv | 20 ++
 rtl/bird_physics.sv | 134 +++++++++++++
 tb/tb_bird_physics.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared constants for the bird physics engine and the downstream death checker,
// so both blocks agree on state encoding and screen limits.
package bird_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FLY  = 2'd1,
      ST_DEAD = 2'd2
   } bird_state_e;

   localparam logic [8:0]        START_H          = 9'd240;
   localparam logic [8:0]        Y_MAX            = 9'd479;
   localparam logic [8:0]        SCREEN_TOP_LIMIT = 9'd10;
   localparam logic [8:0]        SCREEN_BOT_LIMIT = 9'd420;
   localparam logic signed [6:0] GRAV             = 7'sd1;
   localparam logic signed [5:0] FLAP_V           = 6'sd8;
   localparam logic signed [6:0] MAX_FALL         = 7'sd10;
   localparam logic [2:0]        COOLDOWN         = 3'd4;

   // Saturate a signed candidate height into the legal row range [0, Y_MAX].
   function automatic logic [8:0] clamp_height(input logic signed [10:0] h);
      if (h < 11'sd0)
         return '0;
      else if (h > $signed({2'b00, Y_MAX}))
         return Y_MAX;
      else
         return h[8:0];
   endfunction

endpackage

// File: rtl/edge_rise.sv
// 1-bit rising-edge detector with a registered history bit; rise_o is high
// in the clk where sig_i is high and was low on the previous clk.
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic rise_o
);

   logic prev_q;

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= sig_i;
   end

   assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/bird_physics.sv
// Vertical-motion engine for the player sprite: IDLE/FLY/DEAD FSM plus per-frame
// gravity/flap integration. Define FLAP_COOLDOWN_EN to ignore flaps after an accepted one.
module bird_physics
   import bird_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_tick,
   input  logic              flap_btn,
   input  logic              is_dead,
   output logic [8:0]        height,
   output logic signed [5:0] velocity,
   output logic              player_en,
   output logic [1:0]        state
);

   bird_state_e        state_q, state_d;
   logic [8:0]         height_q, height_d;
   logic signed [5:0]  velocity_q, velocity_d;
   logic               flap_pending_q, flap_pending_d;
   logic               flap_edge, flap_ok, take_flap;
   logic signed [6:0]  vel_inc;
   logic signed [5:0]  vel_grav, vel_new;
   logic signed [10:0] height_sum;

   edge_rise u_flap_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (flap_btn),
      .rise_o (flap_edge)
   );

`ifdef FLAP_COOLDOWN_EN
   logic [2:0] cooldown_q, cooldown_d;

   assign flap_ok = flap_edge & (cooldown_q == 3'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cooldown_q <= '0;
      else     cooldown_q <= cooldown_d;
   end
`else
   assign flap_ok = flap_edge;
`endif

   assign take_flap = flap_pending_q | flap_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (flap_edge) state_d = ST_FLY;
         ST_FLY:  if (is_dead)   state_d = ST_DEAD;
         ST_DEAD: if (flap_edge) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      player_en = (state_q == ST_FLY) || (state_q == ST_DEAD);
      state     = state_q;
   end

   always_comb begin
      vel_inc    = $signed({velocity_q[5], velocity_q}) + GRAV;
      vel_grav   = (vel_inc > MAX_FALL) ? MAX_FALL[5:0] : vel_inc[5:0];
      vel_new    = take_flap ? -FLAP_V : vel_grav;
      height_sum = $signed({2'b00, height_q}) + 11'(vel_new);

      height_d       = height_q;
      velocity_d     = velocity_q;
      flap_pending_d = flap_pending_q;
`ifdef FLAP_COOLDOWN_EN
      cooldown_d     = cooldown_q;
`endif

      case (state_q)
         ST_FLY: begin
            // is_dead wins over a coincident frame_tick: no physics on that clk
            if (is_dead) begin
               velocity_d     = '0;
               flap_pending_d = 1'b0;
`ifdef FLAP_COOLDOWN_EN
               cooldown_d     = '0;
`endif
            end else if (frame_tick) begin
               velocity_d     = vel_new;
               height_d       = clamp_height(height_sum);
               flap_pending_d = 1'b0;
`ifdef FLAP_COOLDOWN_EN
               if (take_flap)              cooldown_d = COOLDOWN;
               else if (cooldown_q != 3'd0) cooldown_d = cooldown_q - 3'd1;
`endif
            end else if (flap_ok) begin
               flap_pending_d = 1'b1;
            end
         end
         ST_DEAD: begin
            velocity_d     = '0;
            flap_pending_d = 1'b0;
            if (flap_edge) height_d = START_H;
         end
         default: begin
            height_d       = START_H;
            velocity_d     = '0;
            flap_pending_d = flap_edge;
`ifdef FLAP_COOLDOWN_EN
            cooldown_d     = '0;
`endif
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         height_q       <= START_H;
         velocity_q     <= '0;
         flap_pending_q <= 1'b0;
      end else begin
         height_q       <= height_d;
         velocity_q     <= velocity_d;
         flap_pending_q <= flap_pending_d;
      end
   end

   assign height   = height_q;
   assign velocity = velocity_q;

endmodule

// File: tb/tb_bird_physics.sv
// Self-checking bench for bird_physics: an integer-arithmetic model compared every clk,
// plus hand-computed literal expectations for the directed scenarios.
module tb_bird_physics;

   logic              clk = 1'b0;
   logic              rst;
   logic              frame_tick;
   logic              flap_btn;
   logic              is_dead;
   logic [8:0]        height;
   logic signed [5:0] velocity;
   logic              player_en;
   logic [1:0]        state;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef FLAP_COOLDOWN_EN
   localparam bit CD_ON = 1'b1;
`else
   localparam bit CD_ON = 1'b0;
`endif

   bird_physics dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .flap_btn   (flap_btn),
      .is_dead    (is_dead),
      .height     (height),
      .velocity   (velocity),
      .player_en  (player_en),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_out(input string tag, input int st, input int h, input int v, input int en);
      check({tag, ".state"},     state,     st);
      check({tag, ".height"},    height,    h);
      check({tag, ".velocity"},  velocity,  v);
      check({tag, ".player_en"}, player_en, en);
   endtask

   // Reference model: state 0/1/2 = idle/fly/dead, heights and velocities as plain ints.
   int m_st = 0, m_h = 240, m_v = 0, m_cd = 0;
   bit m_pend = 1'b0, m_prev = 1'b0;

   always @(negedge clk) begin : model_compare
      bit rose, accept, flap;
      if (rst) begin
         m_st = 0; m_h = 240; m_v = 0; m_cd = 0; m_pend = 1'b0; m_prev = 1'b0;
      end
      check("model.state",     state,     m_st);
      check("model.height",    height,    m_h);
      check("model.velocity",  velocity,  m_v);
      check("model.player_en", player_en, (m_st != 0) ? 1 : 0);
      if (!rst) begin
         rose   = flap_btn && !m_prev;
         m_prev = flap_btn;
         accept = rose && !(CD_ON && m_cd > 0);
         case (m_st)
            0: if (rose) begin m_st = 1; m_pend = 1'b1; end
            1: begin
               if (is_dead) begin
                  m_st = 2; m_v = 0; m_pend = 1'b0; m_cd = 0;
               end else if (frame_tick) begin
                  flap = m_pend || accept;
                  m_v  = flap ? -8 : ((m_v + 1 > 10) ? 10 : m_v + 1);
                  m_h  = m_h + m_v;
                  if (m_h < 0)   m_h = 0;
                  if (m_h > 479) m_h = 479;
                  m_pend = 1'b0;
                  m_cd   = flap ? 4 : ((m_cd > 0) ? m_cd - 1 : 0);
               end else if (accept) begin
                  m_pend = 1'b1;
               end
            end
            2: if (rose) begin m_st = 0; m_h = 240; end
            default: ;
         endcase
      end
   end

   // Inputs change 2 time units after the rising edge and are held for one clk.
   task automatic cyc(input bit tick, input bit btn, input bit dead);
      frame_tick = tick;
      flap_btn   = btn;
      is_dead    = dead;
      @(posedge clk);
      #2;
   endtask

   task automatic tick();      cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0); endtask
   task automatic flap_tick(); cyc(1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0); endtask
   task automatic press();     cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0); endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
   endtask

`ifdef FLAP_COOLDOWN_EN
   int t6_h[5] = '{225, 219, 214, 210, 202};
   int t6_v[5] = '{-7, -6, -5, -4, -8};
`else
   int t6_h[5] = '{224, 216, 208, 201, 193};
   int t6_v[5] = '{-8, -8, -8, -7, -8};
`endif

   initial begin
      rst = 1'b1; frame_tick = 1'b0; flap_btn = 1'b0; is_dead = 1'b0;
      @(posedge clk);
      #2;

      // 1: idle after reset ignores ticks and is_dead
      do_reset();
      expect_out("t1_reset", 0, 240, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_out("t1_idle", 0, 240, 0, 0);
      end
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      expect_out("t1_idle_dead", 0, 240, 0, 0);

      // 2: flap from idle, then three plain ticks
      cyc(1'b0, 1'b1, 1'b0);
      expect_out("t2_enter", 1, 240, 0, 1);
      cyc(1'b0, 1'b0, 1'b0);
      tick(); expect_out("t2_tick1", 1, 232, -8, 1);
      tick(); expect_out("t2_tick2", 1, 225, -7, 1);
      tick(); expect_out("t2_tick3", 1, 219, -6, 1);

      // 3: free fall to terminal velocity and bottom clamp
      do_reset();
      press();
      for (int i = 1; i <= 45; i++) begin
         tick();
         if (i == 20) expect_out("t3_tick20", 1, 269, 10, 1);
         if (i == 41) expect_out("t3_tick41", 1, 479, 10, 1);
      end
      expect_out("t3_clamped", 1, 479, 10, 1);

      // 4: flapping into the top of the screen, flap edge coincident with tick
      do_reset();
      press();
      tick();
      for (int i = 0; i < 6; i++) tick();
      expect_out("t4_setup", 1, 205, -2, 1);
      for (int i = 1; i <= 40; i++) begin
         flap_tick();
`ifndef FLAP_COOLDOWN_EN
         if (i == 25) expect_out("t4_h5", 1, 5, -8, 1);
         if (i == 26) expect_out("t4_top_clamp", 1, 0, -8, 1);
`endif
      end
`ifdef FLAP_COOLDOWN_EN
      expect_out("t4_final", 1, 0, -4, 1);
`else
      expect_out("t4_final", 1, 0, -8, 1);
`endif

      // 5: death with coincident tick, restart, asynchronous reset mid-flight
      do_reset();
      press();
      tick();
      tick();
      expect_out("t5_fly", 1, 225, -7, 1);
      cyc(1'b1, 1'b0, 1'b1);
      expect_out("t5_dead", 2, 225, 0, 1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      expect_out("t5_frozen", 2, 225, 0, 1);
      cyc(1'b0, 1'b1, 1'b1);
      expect_out("t5_restart", 0, 240, 0, 0);
      cyc(1'b0, 1'b0, 1'b1);
      expect_out("t5_idle_dead", 0, 240, 0, 0);
      press();
      tick();
      expect_out("t5_refly", 1, 232, -8, 1);
      #1 rst = 1'b1;
      #1 expect_out("t5_async_rst", 0, 240, 0, 0);
      cyc(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      // 6: flaps on consecutive ticks after an accepted flap
      do_reset();
      press();
      tick();
      expect_out("t6_first", 1, 232, -8, 1);
      for (int i = 0; i < 5; i++) begin
         if (i == 3) tick();
         else        flap_tick();
         expect_out($sformatf("t6_tick%0d", i + 1), 1, t6_h[i], t6_v[i], 1);
      end

      // collapsed edges between ticks and a held button (model-checked)
      press();
      press();
      tick();
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
